mod_n_updown_counter: RTL and testbench

//  Parametrised modulo-N up/down counter with programmable step, parallel load,

---
 rtl/mod_n_updown_counter_if.sv | 29 ++
 rtl/mod_n_updown_counter.sv | 103 ++++++++++
 tb/tb_mod_n_updown_counter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mod_n_updown_counter_if.sv
// Counter environment interface: control/data inputs driven by the environment,
// registered count, wrap/err pulses and wrap counter returned by the counter.
interface mod_n_updown_counter_if #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 4,
    parameter int WRAP_W = 8
);
    logic              enable;
    logic              load;
    logic              mode;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  count_in;
    logic [WIDTH-1:0]  count_out;
    logic              wrap;
    logic              err;
    logic [WRAP_W-1:0] wrap_cnt;

    // Environment side: drives controls, observes the counter
    modport master (
        output enable, load, mode, step, count_in,
        input  count_out, wrap, err, wrap_cnt
    );

    // Counter side
    modport slave (
        input  enable, load, mode, step, count_in,
        output count_out, wrap, err, wrap_cnt
    );
endinterface

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with programmable step, parallel load, a one-cycle
// wrap pulse, a one-cycle error pulse and a saturating count of wraps.
module mod_n_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 14,
    parameter int STEP_W  = 4,
    parameter int WRAP_W  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    mod_n_updown_counter_if.slave bus
);
    // Arithmetic width: wide enough for WIDTH+1-bit sums and for the full step
    // input, so MODULUS == 2**WIDTH and oversized steps compare without overflow.
    localparam int CW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;
    localparam logic [CW-1:0]    MOD_C   = CW'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

    if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
        $error("mod_n_updown_counter: MODULUS must lie in 2..2**WIDTH");
    end

    logic [WIDTH-1:0]  count_q, count_d;
    logic              wrap_q, wrap_d;
    logic              err_q, err_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

    logic [CW-1:0] cnt_c, step_c, load_c, sum_c, up_wrapped_c, down_wrapped_c;
    logic          step_bad;

    // Widened operands and candidate results for both directions
    always_comb begin
        cnt_c          = CW'(count_q);
        step_c         = CW'(bus.step);
        load_c         = CW'(bus.count_in);
        sum_c          = cnt_c + step_c;
        up_wrapped_c   = sum_c - MOD_C;
        down_wrapped_c = cnt_c + MOD_C - step_c;
        step_bad       = (step_c == '0) || (step_c >= MOD_C);
    end

    // Next-state selection: reset is handled in the register, then load beats enable
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (bus.load) begin
            if (load_c < MOD_C) begin
                count_d = bus.count_in;
            end else begin
                // Out-of-range load clamps to the top of the range and flags it
                count_d = MAX_CNT;
                err_d   = 1'b1;
            end
        end else if (bus.enable) begin
            if (step_bad) begin
                err_d = 1'b1;
            end else if (bus.mode) begin
                if (sum_c >= MOD_C) begin
                    count_d = up_wrapped_c[WIDTH-1:0];
                    wrap_d  = 1'b1;
                end else begin
                    count_d = sum_c[WIDTH-1:0];
                end
            end else begin
                if (cnt_c >= step_c) begin
                    count_d = count_q - step_c[WIDTH-1:0];
                end else begin
                    count_d = down_wrapped_c[WIDTH-1:0];
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    // Wrap counter saturates at all-ones instead of rolling over
    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (wrap_d && (wrap_cnt_q != {WRAP_W{1'b1}})) begin
            wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
        end
    end

    // State register with synchronous reset overriding load and enable
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
            wrap_cnt_q <= '0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign bus.count_out = count_q;
    assign bus.wrap      = wrap_q;
    assign bus.err       = err_q;
    assign bus.wrap_cnt  = wrap_cnt_q;
endmodule

// File: tb/tb_mod_n_updown_counter.sv
module tb_mod_n_updown_counter;
    logic clk;
    logic rst_a;
    logic rst_b;

    int total;
    int bad;

    // Main DUT: WIDTH=4, MODULUS=14, WRAP_W=8
    mod_n_updown_counter_if #(.WIDTH(4), .STEP_W(4), .WRAP_W(8)) bus0 ();
    mod_n_updown_counter #(.WIDTH(4), .MODULUS(14), .STEP_W(4), .WRAP_W(8)) dut0 (
        .clock(clk), .reset(rst_a), .bus(bus0)
    );

    // Saturation DUT: WRAP_W=2
    mod_n_updown_counter_if #(.WIDTH(4), .STEP_W(4), .WRAP_W(2)) bus1 ();
    mod_n_updown_counter #(.WIDTH(4), .MODULUS(14), .STEP_W(4), .WRAP_W(2)) dut1 (
        .clock(clk), .reset(rst_b), .bus(bus1)
    );

    // Full-range DUT: MODULUS=16
    mod_n_updown_counter_if #(.WIDTH(4), .STEP_W(4), .WRAP_W(8)) bus2 ();
    mod_n_updown_counter #(.WIDTH(4), .MODULUS(16), .STEP_W(4), .WRAP_W(8)) dut2 (
        .clock(clk), .reset(rst_b), .bus(bus2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic       en;
        logic       ld;
        logic       md;
        logic [3:0] st;
        logic [3:0] cin;
        logic [3:0] e_cnt;
        logic       e_wrap;
        logic       e_err;
        logic [7:0] e_wcnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic e, input logic l, input logic m,
                                input int st, input int cin, input int ec,
                                input logic ew, input logic ee, input int ewc);
        vec_t v;
        v.rst = r; v.en = e; v.ld = l; v.md = m;
        v.st = 4'(st); v.cin = 4'(cin);
        v.e_cnt = 4'(ec); v.e_wrap = ew; v.e_err = ee; v.e_wcnt = 8'(ewc);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic e, input logic l, input logic m, input int st, input int cin);
        bus1.enable = e; bus1.load = l; bus1.mode = m;
        bus1.step = 4'(st); bus1.count_in = 4'(cin);
    endtask

    task automatic drive2(input logic e, input logic l, input logic m, input int st, input int cin);
        bus2.enable = e; bus2.load = l; bus2.mode = m;
        bus2.step = 4'(st); bus2.count_in = 4'(cin);
    endtask

    // Reference model state for the randomized phase
    int m_cnt;
    int m_wcnt;

    initial begin
        int m_wrap;
        int m_err;
        int r_rst, r_en, r_ld, r_md, r_st, r_cin;
        int exp_wcnt1[5];
        total = 0;
        bad   = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus0.enable = 0; bus0.load = 0; bus0.mode = 0; bus0.step = 0; bus0.count_in = 0;
        drive1(0, 0, 0, 0, 0);
        drive2(0, 0, 0, 0, 0);

        // ---- directed table: reset, up/down wraps, loads, illegal steps, mid-run reset
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 13; i++) vecs.push_back(mk(0, 1, 0, 1, 1, 0, i, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0, 13, 1, 0, 2));
        vecs.push_back(mk(0, 0, 1, 0, 0, 3, 3, 0, 0, 2));
        vecs.push_back(mk(0, 1, 0, 0, 5, 0, 12, 1, 0, 3));
        vecs.push_back(mk(0, 1, 0, 1, 5, 0, 3, 1, 0, 4));
        vecs.push_back(mk(0, 0, 1, 0, 0, 9, 9, 0, 0, 4));
        vecs.push_back(mk(0, 0, 1, 0, 0, 15, 13, 0, 1, 4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 13, 0, 0, 4));
        vecs.push_back(mk(0, 1, 1, 1, 1, 4, 4, 0, 0, 4));
        vecs.push_back(mk(0, 0, 1, 0, 0, 6, 6, 0, 0, 4));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 6, 0, 1, 4));
        vecs.push_back(mk(0, 1, 0, 1, 14, 0, 6, 0, 1, 4));
        vecs.push_back(mk(0, 1, 0, 0, 15, 0, 6, 0, 1, 4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 6, 0, 0, 4));
        vecs.push_back(mk(0, 0, 1, 0, 0, 7, 7, 0, 0, 4));
        vecs.push_back(mk(1, 1, 1, 1, 1, 3, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            rst_a = vecs[i].rst;
            bus0.enable = vecs[i].en; bus0.load = vecs[i].ld; bus0.mode = vecs[i].md;
            bus0.step = vecs[i].st; bus0.count_in = vecs[i].cin;
            tick();
            $display("vec %0d: rst=%0d en=%0d ld=%0d md=%0d st=%0d cin=%0d -> cnt=%0d wrap=%0d err=%0d wcnt=%0d",
                     i, vecs[i].rst, vecs[i].en, vecs[i].ld, vecs[i].md, vecs[i].st, vecs[i].cin,
                     bus0.count_out, bus0.wrap, bus0.err, bus0.wrap_cnt);
            chk($sformatf("vec%0d_count", i), 32'(bus0.count_out), 32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_wrap", i), 32'(bus0.wrap), 32'(vecs[i].e_wrap));
            chk($sformatf("vec%0d_err", i), 32'(bus0.err), 32'(vecs[i].e_err));
            chk($sformatf("vec%0d_wcnt", i), 32'(bus0.wrap_cnt), 32'(vecs[i].e_wcnt));
        end

        // ---- randomized phase against a modular-arithmetic reference model
        m_cnt  = 0;
        m_wcnt = 0;
        for (int n = 0; n < 300; n++) begin
            r_rst = ($urandom_range(0, 49) == 0) ? 1 : 0;
            r_ld  = ($urandom_range(0, 6) == 0) ? 1 : 0;
            r_en  = ($urandom_range(0, 9) < 7) ? 1 : 0;
            r_md  = int'($urandom_range(0, 1));
            r_st  = int'($urandom_range(0, 15));
            r_cin = int'($urandom_range(0, 15));
            m_wrap = 0;
            m_err  = 0;
            if (r_rst != 0) begin
                m_cnt = 0; m_wcnt = 0;
            end else if (r_ld != 0) begin
                if (r_cin < 14) m_cnt = r_cin;
                else begin m_cnt = 13; m_err = 1; end
            end else if (r_en != 0) begin
                if (r_st == 0 || r_st >= 14) m_err = 1;
                else if (r_md != 0) begin
                    m_wrap = (m_cnt + r_st >= 14) ? 1 : 0;
                    m_cnt  = (m_cnt + r_st) % 14;
                end else begin
                    m_wrap = (m_cnt < r_st) ? 1 : 0;
                    m_cnt  = (m_cnt - r_st + 14) % 14;
                end
            end
            if (m_wrap != 0 && m_wcnt < 255) m_wcnt++;

            rst_a = 1'(r_rst);
            bus0.enable = 1'(r_en); bus0.load = 1'(r_ld); bus0.mode = 1'(r_md);
            bus0.step = 4'(r_st); bus0.count_in = 4'(r_cin);
            tick();
            $display("rnd %0d: rst=%0d en=%0d ld=%0d md=%0d st=%0d cin=%0d -> cnt=%0d wrap=%0d err=%0d wcnt=%0d",
                     n, r_rst, r_en, r_ld, r_md, r_st, r_cin,
                     bus0.count_out, bus0.wrap, bus0.err, bus0.wrap_cnt);
            chk("rnd_count", 32'(bus0.count_out), 32'(m_cnt));
            chk("rnd_wrap", 32'(bus0.wrap), 32'(m_wrap));
            chk("rnd_err", 32'(bus0.err), 32'(m_err));
            chk("rnd_wcnt", 32'(bus0.wrap_cnt), 32'(m_wcnt));
        end
        rst_a = 1'b0;
        bus0.enable = 0; bus0.load = 0;

        // ---- WRAP_W=2 saturation: down by 13 from 0 wraps every cycle
        rst_b = 1'b1;
        drive1(0, 0, 0, 0, 0);
        drive2(0, 0, 0, 0, 0);
        tick();
        chk("sat_reset_wcnt", 32'(bus1.wrap_cnt), 32'd0);
        rst_b = 1'b0;
        exp_wcnt1 = '{1, 2, 3, 3, 3};
        for (int k = 0; k < 5; k++) begin
            drive1(1, 0, 0, 13, 0);
            tick();
            $display("sat %0d: cnt=%0d wrap=%0d wcnt=%0d", k, bus1.count_out, bus1.wrap, bus1.wrap_cnt);
            chk($sformatf("sat%0d_count", k), 32'(bus1.count_out), 32'(k + 1));
            chk($sformatf("sat%0d_wrap", k), 32'(bus1.wrap), 32'd1);
            chk($sformatf("sat%0d_wcnt", k), 32'(bus1.wrap_cnt), 32'(exp_wcnt1[k]));
        end
        drive1(0, 0, 0, 0, 0);
        tick();
        chk("sat_idle_wrap", 32'(bus1.wrap), 32'd0);
        chk("sat_idle_wcnt", 32'(bus1.wrap_cnt), 32'd3);

        // ---- MODULUS=16: full-range wrap in both directions
        drive2(0, 1, 0, 0, 15);
        tick();
        $display("m16 load: cnt=%0d err=%0d", bus2.count_out, bus2.err);
        chk("m16_load15", 32'(bus2.count_out), 32'd15);
        chk("m16_load15_err", 32'(bus2.err), 32'd0);
        drive2(1, 0, 1, 1, 0);
        tick();
        $display("m16 up: cnt=%0d wrap=%0d wcnt=%0d", bus2.count_out, bus2.wrap, bus2.wrap_cnt);
        chk("m16_up_count", 32'(bus2.count_out), 32'd0);
        chk("m16_up_wrap", 32'(bus2.wrap), 32'd1);
        chk("m16_up_wcnt", 32'(bus2.wrap_cnt), 32'd1);
        drive2(1, 0, 0, 1, 0);
        tick();
        $display("m16 down: cnt=%0d wrap=%0d wcnt=%0d", bus2.count_out, bus2.wrap, bus2.wrap_cnt);
        chk("m16_down_count", 32'(bus2.count_out), 32'd15);
        chk("m16_down_wrap", 32'(bus2.wrap), 32'd1);
        chk("m16_down_wcnt", 32'(bus2.wrap_cnt), 32'd2);
        drive2(1, 0, 1, 15, 0);
        tick();
        $display("m16 up15: cnt=%0d wrap=%0d err=%0d", bus2.count_out, bus2.wrap, bus2.err);
        chk("m16_up15_count", 32'(bus2.count_out), 32'd14);
        chk("m16_up15_wrap", 32'(bus2.wrap), 32'd1);
        chk("m16_up15_err", 32'(bus2.err), 32'd0);
        drive2(1, 0, 1, 1, 0);
        tick();
        chk("m16_noover_count", 32'(bus2.count_out), 32'd15);
        chk("m16_noover_wrap", 32'(bus2.wrap), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
